pyramid_level_arbiter: RTL
==========================

Name: pyramid_level_arbiter

Overview:
- Sits directly downstream of the Gaussian pyramid.
- Consumes its LEVELS parallel valid/ready pixel streams and serialises them into a single stream, tagging each pixel with its level index.
- Each level has a small FIFO to absorb bursts, so no pyramid level stalls while another is being served.
- A round-robin arbiter guarantees fairness; the output feeds the single shared gradient/HOG front end.

Parameters:
- DATA_WIDTH, 8: pixel width in bits.
- LEVELS, 15: number of pyramid levels (input streams).
- FIFO_DEPTH, 4: entries per level FIFO; power of two, >= 2.
- LEVEL_W, $clog2(LEVELS) (min 1): width of the level tag; derived, not overridden.
- IN_WIDTH, DATA_WIDTH*LEVELS: width of the concatenated input pixel bus.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low (rst=0 resets).
- in_valid  input  LEVELS  per-level pixel valid (bit i = level i).
- in_ready  output  LEVELS  per-level ready; bit i = level i FIFO not full and not in reset.
- pyramid_pixels  input  IN_WIDTH  level i pixel at [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  output  1  output pixel valid.
- out_ready  input  1  downstream ready.
- out_pixel  output  DATA_WIDTH  serialised pixel.
- out_level  output  LEVEL_W  level index of out_pixel.

Behaviour:
- Push rule
  - Level i push occurs on a rising edge where in_valid[i] && in_ready[i].
  - in_ready[i] = !full[i] && rst. It never depends on in_valid.
  - A full FIFO does not accept a push even in a cycle where it is popped (no push-through-full).
- Arbitration (combinational in each cycle)
  - Candidates are the non-empty FIFOs.
  - Search starts at (last_grant+1) mod LEVELS and wraps; the first candidate found wins.
  - last_grant updates only on an actual pop.
- Output register
  - out_valid/out_pixel/out_level are registered.
  - Load enable = (!out_valid || out_ready) && any FIFO non-empty.
  - On load, the winning FIFO is popped; out_pixel takes its head and out_level takes its index.
  - If load enable is false and out_ready && out_valid, out_valid clears to 0.
- Latency: a pixel pushed into an empty FIFO at edge k, with the output slot free and no competing level, gives out_valid=1 after edge k+1.
- Throughput: one pixel per clock when out_ready is held high and at least one FIFO is non-empty.
- Stall: while out_valid && !out_ready, out_pixel and out_level are held stable and no FIFO is popped.
- Ordering: per-level order is preserved; no pixel is dropped or duplicated.
- Fairness: with k levels continuously non-empty, each is granted exactly once in every k consecutive grants.
- Simultaneous push and pop on the same non-full FIFO are both performed; occupancy is unchanged.
- Reset values (rst=0 at an edge)
  - out_valid=0, out_pixel=0, out_level=0.
  - All FIFO pointers and counts = 0.
  - last_grant=LEVELS-1, so level 0 has first priority.
- Reset mid-operation discards all buffered pixels. in_ready is 0 for the whole reset cycle.
- FIFO occupancy counters are $clog2(FIFO_DEPTH)+1 bits wide; read/write pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Shared package pyramid_pkg holds:
  - the clog2 helper function;
  - DATA_WIDTH and LEVELS defaults, so the pyramid and the arbiter agree.
- One sub-module, level_fifo: a synchronous FIFO (clk, rst active-low, push, pop, din, dout, full, empty, parameterised depth/width), instantiated LEVELS times in a generate loop.
- The round-robin arbiter stays inline.

Test Plan:
- Single pixel: reset, then level 3 sends 0xA5 with out_ready=1 → after 1 edge out_valid=1, out_pixel=0xA5, out_level=3; next edge out_valid=0.
- Fairness: all 15 levels send pixel value = level index at the same cycle, out_ready=1 → outputs in level order 0,1,...,14 on consecutive cycles, then 3 more rounds identical when each level has 4 queued.
- Backpressure: out_ready=0, level 0 streams continuously → 1 pixel held in the output register, 4 in the FIFO; in_ready[0] drops after the 5th accept and out_pixel stays constant. Raise out_ready → 5 pixels emerge in order on 5 consecutive cycles.
- Fairness under load: levels 2 and 9 continuously valid, out_ready=1 → out_level alternates 2,9,2,9...; sequence per level is strictly incrementing.
- Reset mid-operation: fill levels 0–4 with 3 pixels each, assert rst=0 for one edge → out_valid=0, all in_ready=0 during reset. After release the first output comes from newly pushed data only (no stale pixels).
- Random stress: random in_valid and out_ready at 50% over 10k cycles → scoreboard shows per-level order preserved, zero loss/duplication, and stable output whenever stalled.

Source files
------------

// File: rtl/pyramid_pkg.sv
// Shared constants and helpers so the Gaussian pyramid and its downstream
// arbiter agree on pixel width and level count.
package pyramid_pkg;

  localparam int PYR_DATA_WIDTH = 8;
  localparam int PYR_LEVELS     = 15;

  // Ceiling log2 that never returns less than 1, so one-entry indices still get a bit.
  function automatic int clog2_min1(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/pyramid_level_arbiter_if.sv
// Bundle of the per-level input streams and the single serialised output stream.
interface pyramid_level_arbiter_if
  import pyramid_pkg::*;
#(
  parameter int DATA_WIDTH = PYR_DATA_WIDTH,
  parameter int LEVELS     = PYR_LEVELS
);
  localparam int LEVEL_W  = clog2_min1(LEVELS);
  localparam int IN_WIDTH = DATA_WIDTH * LEVELS;

  logic [LEVELS-1:0]     in_valid;
  logic [LEVELS-1:0]     in_ready;
  logic [IN_WIDTH-1:0]   pyramid_pixels;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_pixel;
  logic [LEVEL_W-1:0]    out_level;

  modport slave (
    input  in_valid, pyramid_pixels, out_ready,
    output in_ready, out_valid, out_pixel, out_level
  );

  modport master (
    output in_valid, pyramid_pixels, out_ready,
    input  in_ready, out_valid, out_pixel, out_level
  );

endinterface

// File: rtl/pyramid_level_arbiter_fifo.sv
// Small synchronous FIFO absorbing bursts from one pyramid level; head is
// presented combinationally on dout while not empty.
module level_fifo
  import pyramid_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = clog2_min1(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Full blocks a push even when the same cycle pops: no push-through-full.
  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign do_push_s = push && !full && rst;
  assign do_pop_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r];

  // Pointer and occupancy state; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

endmodule

// File: rtl/pyramid_level_arbiter.sv
// Serialises the pyramid level streams into one tagged stream through per-level
// FIFOs and a round-robin arbiter feeding a registered output slot.
module pyramid_level_arbiter
  import pyramid_pkg::*;
#(
  parameter int DATA_WIDTH = PYR_DATA_WIDTH,
  parameter int LEVELS     = PYR_LEVELS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  pyramid_level_arbiter_if.slave  bus
);

  localparam int LEVEL_W = clog2_min1(LEVELS);

  logic [LEVELS-1:0]     full_s;
  logic [LEVELS-1:0]     empty_s;
  logic [LEVELS-1:0]     push_s;
  logic [LEVELS-1:0]     pop_s;
  logic [DATA_WIDTH-1:0] head_s [LEVELS];
  logic                  grant_found_s;
  logic [LEVEL_W-1:0]    grant_idx_s;
  logic                  load_s;

  logic                  out_valid_r;
  logic [DATA_WIDTH-1:0] out_pixel_r;
  logic [LEVEL_W-1:0]    out_level_r;
  logic [LEVEL_W-1:0]    last_grant_r;

  assign bus.in_ready  = ~full_s & {LEVELS{rst}};
  assign push_s        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = out_valid_r;
  assign bus.out_pixel = out_pixel_r;
  assign bus.out_level = out_level_r;

  for (genvar g = 0; g < LEVELS; g++) begin : g_level
    level_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_WIDTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s[g]),
      .pop   (pop_s[g]),
      .din   (bus.pyramid_pixels[g*DATA_WIDTH +: DATA_WIDTH]),
      .dout  (head_s[g]),
      .full  (full_s[g]),
      .empty (empty_s[g])
    );
  end

  // Round-robin search starting just after the last granted level, wrapping once.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {LEVEL_W{1'b0}};
    for (int k = 0; k < LEVELS; k++) begin
      int   cand;
      logic take;
      cand = int'(last_grant_r) + 1 + k;
      cand = (cand >= LEVELS) ? (cand - LEVELS) : cand;
      take = !grant_found_s && !empty_s[cand];
      grant_idx_s   = take ? LEVEL_W'(cand) : grant_idx_s;
      grant_found_s = grant_found_s || take;
    end
  end

  assign load_s = (!out_valid_r || bus.out_ready) && grant_found_s;

  // One-hot pop of the winning FIFO, only when the output slot actually loads.
  always_comb begin
    pop_s = {LEVELS{1'b0}};
    if (load_s) begin
      pop_s[grant_idx_s] = 1'b1;
    end else begin
      pop_s = {LEVELS{1'b0}};
    end
  end

  // Output slot and arbiter history; last_grant resets so level 0 wins first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_r  <= 1'b0;
      out_pixel_r  <= {DATA_WIDTH{1'b0}};
      out_level_r  <= {LEVEL_W{1'b0}};
      last_grant_r <= LEVEL_W'(LEVELS - 1);
    end else if (load_s) begin
      out_valid_r  <= 1'b1;
      out_pixel_r  <= head_s[grant_idx_s];
      out_level_r  <= grant_idx_s;
      last_grant_r <= grant_idx_s;
    end else if (bus.out_ready && out_valid_r) begin
      out_valid_r  <= 1'b0;
    end else begin
      out_valid_r  <= out_valid_r;
    end
  end

endmodule
